mac_stream_feeder: RTL and testbench

- Initiator side of the mac operand interface. It is the sequencer that drives x/c operand pairs into a mac instance and collects the accumulated result.
- On a start pulse it:
  - clears the mac;
  - streams N input/weight pairs from two synchronous-read memories;
  - captures the mac output and applies optional ReLU;
  - presents one neuron result on a valid/ready output.
- Sits between the layer's input/weight buffers and one mac; the layer controller instantiates one per neuron lane.

---
 rtl/mac_stream_feeder.sv | 92 +++++++++
 tb/tb_mac_stream_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_feeder.sv
// Operand sequencer for one mac lane: clears the mac, streams N x/c pairs from
// two 1-cycle-latency buffers, captures the sum (optional ReLU) and hands it off.
module mac_stream_feeder #(
  parameter int W     = 4,
  parameter int N     = 16,
  parameter int ACC_W = 12,
  parameter int AW    = (N > 1) ? $clog2(N) : 1,
  parameter bit RELU  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [AW-1:0]    x_addr_o,
  input  logic [W-1:0]     x_rdata_i,
  output logic [AW-1:0]    w_addr_o,
  input  logic [W-1:0]     w_rdata_i,
  output logic             mac_rst_o,
  output logic [W-1:0]     mac_x_o,
  output logic [W-1:0]     mac_c_o,
  input  logic [ACC_W-1:0] mac_o_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o
);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, CAPTURE, OUT} state_e;

  localparam logic [AW-1:0] KLAST = AW'(N - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic             opv_q, opv_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic [AW-1:0]    addr;
  logic             last_k;

  assign last_k = (k_q == KLAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      opv_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opv_q   <= opv_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    out_d   = out_q;
    addr    = '0;
    case (state_q)
      IDLE:    if (start_i) state_d = CLR;
      CLR: begin
        k_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        // Prefetch the next element; the last one holds its own address.
        addr = last_k ? k_q : k_q + 1'b1;
        if (last_k) state_d = CAPTURE;
        else        k_d     = k_q + 1'b1;
      end
      CAPTURE: begin
        out_d   = (RELU && mac_o_i[ACC_W-1]) ? '0 : mac_o_i;
        state_d = OUT;
      end
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The mac has no enable, so operands must read as zero whenever no pair is issued.
  assign opv_d = (state_d == STREAM);

  assign busy_o      = (state_q != IDLE);
  assign x_addr_o    = addr;
  assign w_addr_o    = addr;
  assign mac_rst_o   = rst_i | (state_q == CLR);
  assign mac_x_o     = opv_q ? x_rdata_i : '0;
  assign mac_c_o     = opv_q ? w_rdata_i : '0;
  assign out_valid_o = (state_q == OUT);
  assign out_data_o  = out_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Scoreboarded bench: three feeder lanes (N=3, N=3 with ReLU, N=16), each with its
// own buffers and mac model; results are predicted from plain dot-product arithmetic.
module tb_mac_stream_feeder;
  localparam int W = 4, ACC_W = 12, L = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    start[L], out_ready[L];
  logic                    busy[L], out_valid[L], mac_rst[L];
  logic signed [W-1:0]     mac_x[L], mac_c[L];
  logic [3:0]              addr_a[L];
  logic signed [ACC_W-1:0] out_data[L];
  logic signed [W-1:0]     xmem[L][16], wmem[L][16];

  int total = 0, bad = 0;
  int exp_q[L][$];

  function automatic int lane_n(input int g);
    return (g == 2) ? 16 : 3;
  endfunction
  function automatic int lane_relu(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < L; g++) begin : g_lane
    localparam int NN  = (g == 2) ? 16 : 3;
    localparam int AWW = $clog2(NN);
    localparam bit RR  = (g == 1);
    logic [AWW-1:0]          xa, wa;
    logic signed [W-1:0]     xr, wr, mx, mc;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]        od;
    logic                    bz, ov, mr;

    always_ff @(posedge clk) begin
      xr <= xmem[g][4'(xa)];
      wr <= wmem[g][4'(wa)];
    end
    always_ff @(posedge clk) begin
      if (mr) acc <= '0;
      else    acc <= acc + mx * mc;
    end

    mac_stream_feeder #(.W(W), .N(NN), .ACC_W(ACC_W), .RELU(RR)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start[g]), .busy_o(bz),
      .x_addr_o(xa), .x_rdata_i(xr), .w_addr_o(wa), .w_rdata_i(wr),
      .mac_rst_o(mr), .mac_x_o(mx), .mac_c_o(mc), .mac_o_i(acc),
      .out_valid_o(ov), .out_ready_i(out_ready[g]), .out_data_o(od)
    );

    assign busy[g]      = bz;
    assign out_valid[g] = ov;
    assign mac_rst[g]   = mr;
    assign mac_x[g]     = mx;
    assign mac_c[g]     = mc;
    assign addr_a[g]    = 4'(xa);
    assign out_data[g]  = od;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_neuron(input int g);
    int s = 0;
    for (int i = 0; i < lane_n(g); i++) s += int'(xmem[g][i]) * int'(wmem[g][i]);
    return (lane_relu(g) != 0 && s < 0) ? 0 : s;
  endfunction

  // Monitor: every completed handshake must match the oldest prediction.
  int mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < L; g++) begin
        if (out_valid[g] && out_ready[g]) begin
          if (exp_q[g].size() == 0) chk($sformatf("unexpected_out%0d", g), out_data[g], 0);
          else begin
            mon_e = exp_q[g].pop_front();
            chk($sformatf("result_lane%0d", g), out_data[g], mon_e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set3(input int g, input int x0, x1, x2, w0, w1, w2);
    xmem[g][0] = 4'(x0); xmem[g][1] = 4'(x1); xmem[g][2] = 4'(x2);
    wmem[g][0] = 4'(w0); wmem[g][1] = 4'(w1); wmem[g][2] = 4'(w2);
  endtask

  task automatic run(input int g, input bit rnd, input int exp_lat);
    int n = 0;
    exp_q[g].push_back(ref_neuron(g));
    start[g] = 1'b1; step(); start[g] = 1'b0;
    while (busy[g] && n < 300) begin
      if (rnd) out_ready[g] = 1'($urandom_range(0, 1));
      step(); n++;
    end
    out_ready[g] = 1'b1;
    chk($sformatf("run_done_lane%0d", g), busy[g], 0);
    if (exp_lat > 0) chk($sformatf("latency_lane%0d", g), n, exp_lat);
  endtask

  logic signed [W-1:0]     sx[8], sc[8];
  logic                    sm[8], sv[8], sb[8];
  logic [3:0]              sa[8];
  logic signed [ACC_W-1:0] sd[8];

  initial begin
    int n;
    rst = 1'b1;
    for (int g = 0; g < L; g++) begin
      start[g] = 1'b0; out_ready[g] = 1'b1;
      for (int i = 0; i < 16; i++) begin xmem[g][i] = '0; wmem[g][i] = '0; end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < L; g++) begin
      chk("rst_busy", busy[g], 0);
      chk("rst_valid", out_valid[g], 0);
      chk("rst_data", out_data[g], 0);
      chk("rst_macrst", mac_rst[g], 1);
      chk("rst_macx", mac_x[g], 0);
      chk("rst_macc", mac_c[g], 0);
      chk("rst_addr", addr_a[g], 0);
    end
    step(); rst = 1'b0;
    step();

    // Basic cycle-accurate run on lane 0.
    set3(0, 4, 6, -4, -3, -1, -3);
    exp_q[0].push_back(ref_neuron(0));
    start[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sx[c] = mac_x[0]; sc[c] = mac_c[0]; sm[c] = mac_rst[0];
      sv[c] = out_valid[0]; sb[c] = busy[0]; sa[c] = addr_a[0]; sd[c] = out_data[0];
      step(); start[0] = 1'b0;
    end
    chk("b_mrst0", sm[0], 0); chk("b_mrst1", sm[1], 1); chk("b_mrst2", sm[2], 0);
    chk("b_busy0", sb[0], 0); chk("b_busy1", sb[1], 1);
    chk("b_addr1", sa[1], 0); chk("b_addr2", sa[2], 1);
    chk("b_addr3", sa[3], 2); chk("b_addr4", sa[4], 2);
    chk("b_x1", sx[1], 0);  chk("b_c1", sc[1], 0);
    chk("b_x2", sx[2], 4);  chk("b_c2", sc[2], -3);
    chk("b_x3", sx[3], 6);  chk("b_c3", sc[3], -1);
    chk("b_x4", sx[4], -4); chk("b_c4", sc[4], -3);
    chk("b_x5", sx[5], 0);  chk("b_c5", sc[5], 0);
    chk("b_valid5", sv[5], 0); chk("b_valid6", sv[6], 1);
    chk("b_data6", sd[6], -6);
    chk("b_busy6", sb[6], 1); chk("b_busy7", sb[7], 0);

    // ReLU lane.
    set3(1, 4, 6, -4, -3, -1, -3);
    run(1, 0, 6);
    set3(1, 4, 6, -4, 3, 1, 3);
    run(1, 0, 6);

    // Backpressure with ignored start pulses during OUT.
    set3(0, 4, 6, -4, -3, -1, -3);
    out_ready[0] = 1'b0;
    exp_q[0].push_back(ref_neuron(0));
    start[0] = 1'b1; step(); start[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 50) begin step(); n++; end
    chk("bp_valid", out_valid[0], 1);
    for (int i = 0; i < 5; i++) begin
      start[0] = (i % 2 == 0);
      @(negedge clk);
      chk("bp_hold", out_data[0], -6);
      chk("bp_busy", busy[0], 1);
      step();
    end
    start[0] = 1'b0; out_ready[0] = 1'b1;
    n = 0;
    while (busy[0] && n < 20) begin step(); n++; end
    chk("bp_release", busy[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_idle_busy", busy[0], 0);
      chk("bp_idle_valid", out_valid[0], 0);
      step();
    end

    // Back-to-back runs with different weights.
    set3(0, 4, 6, -4, -3, -1, -3);
    run(0, 0, 6);
    set3(0, 4, 6, -4, $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, 5);
    run(0, 0, 6);

    // Extremes on the 16-element lane.
    for (int i = 0; i < 16; i++) begin xmem[2][i] = -4'sd8; wmem[2][i] = -4'sd8; end
    run(2, 0, 19);
    for (int i = 0; i < 16; i++) wmem[2][i] = 4'sd7;
    run(2, 0, 19);

    // Reset in the middle of STREAM, then a clean run.
    set3(0, 4, 6, -4, -3, -1, -3);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("ra_macrst_cyc4", mac_rst[0], 1);
    step();
    @(negedge clk);
    chk("ra_busy", busy[0], 0);
    chk("ra_valid", out_valid[0], 0);
    chk("ra_macrst", mac_rst[0], 1);
    chk("ra_macx", mac_x[0], 0);
    chk("ra_macc", mac_c[0], 0);
    step(); rst = 1'b0;
    step();
    set3(0, -2, 7, 3, 5, -6, 1);
    run(0, 0, 6);

    // Randomized runs with random backpressure.
    for (int it = 0; it < 15; it++) begin
      int g;
      g = $urandom_range(0, L - 1);
      for (int i = 0; i < 16; i++) begin
        xmem[g][i] = 4'($urandom_range(0, 15));
        wmem[g][i] = 4'($urandom_range(0, 15));
      end
      run(g, 1, 0);
    end

    repeat (3) step();
    for (int g = 0; g < L; g++) chk($sformatf("pending_lane%0d", g), exp_q[g].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
